// File: rtl/seg7_pkg.sv
// seg7_pkg: shared widths, A..G segment patterns (A is MSB) and BCD decode function
package seg7_pkg;
  localparam int BCD_W = 4;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_BAD = 7'b1111111;

  function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BAD;
    endcase
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-high A..G segment pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);
  assign seg = seg_decode(bcd);
endmodule

// File: rtl/seg7_bcd_counter.sv
// seg7_bcd_counter: prescaled multi-digit BCD up/down counter with multiplexed 7-segment scan
module seg7_bcd_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int PRESCALE   = 4,
  parameter int SCAN_DIV   = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    wrap,
  output logic [SEG_W-1:0]        seg,
  output logic [DIGITS-1:0]       dig_sel
);
  localparam int W  = BCD_W * DIGITS;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0] pre_cnt;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic step, scan_done;
  logic [W-1:0] nxt, ld;
  logic [DIGITS:0] c;
  logic [BCD_W-1:0] dgt [DIGITS];
  logic [SEG_W-1:0] seg_nxt, seg_q;
  logic [DIGITS-1:0] sel_q;
  assign step = en && pre_cnt == PW'(PRESCALE - 1);
  assign c[0] = 1'b1;
  // c[i] is the carry (up) or borrow (down) into digit i; c[DIGITS] means roll-over
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [BCD_W-1:0] d, l;
    assign d = count[BCD_W*i +: BCD_W];
    assign l = load_val[BCD_W*i +: BCD_W];
    assign dgt[i] = d;
    assign c[i+1] = c[i] && (up ? d == 4'd9 : d == 4'd0);
    assign nxt[BCD_W*i +: BCD_W] = !c[i] ? d : up ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
    assign ld[BCD_W*i +: BCD_W] = l > 4'd9 ? 4'd9 : l;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear || load) pre_cnt <= '0;
    else if (en) pre_cnt <= step ? '0 : pre_cnt + PW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear) count <= '0;
    else if (load) count <= ld;
    else if (step) count <= nxt;
  end
  always_ff @(posedge clk) wrap <= rst_n && !clear && !load && step && c[DIGITS];
  assign scan_done = scan_cnt == SW'(SCAN_DIV - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_q    <= SEG_0;
      sel_q    <= DIGITS'(1);
    end else begin
      scan_cnt <= scan_done ? '0 : scan_cnt + SW'(1);
      idx      <= !scan_done ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      seg_q    <= seg_nxt;
      sel_q    <= DIGITS'(1) << idx;
    end
  end
  seg7_decode u_dec (.bcd(dgt[idx]), .seg(seg_nxt));
  assign seg     = ACTIVE_LOW != 0 ? ~seg_q : seg_q;
  assign dig_sel = ACTIVE_LOW != 0 ? ~sel_q : sel_q;
endmodule

// File: tb/tb_seg7_bcd_counter.sv
// tb_seg7_bcd_counter: directed checks of counting, wrap, priority, scan and active-low outputs
module tb_seg7_bcd_counter;
  logic clk = 1'b0;
  logic rst_n, en, up, clear, load;
  logic [7:0] load_val;
  logic [7:0] count, count_al;
  logic wrap, wrap_al;
  logic [6:0] seg, seg_al;
  logic [1:0] dig_sel, dig_al;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_bcd_counter #(.DIGITS(2), .PRESCALE(4), .SCAN_DIV(2), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count), .wrap(wrap), .seg(seg), .dig_sel(dig_sel));

  seg7_bcd_counter #(.DIGITS(2), .PRESCALE(4), .SCAN_DIV(2), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count_al), .wrap(wrap_al), .seg(seg_al), .dig_sel(dig_al));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    en = 1'b0; load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    logic [1:0] exp_sel [5];
    exp_sel = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
    rst_n = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00;
    tick(2);
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", count); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (seg !== 7'b1111110) begin failures++; $display("FAIL reset_seg got=%b exp=1111110", seg); end
    checks++; if (dig_sel !== 2'b01) begin failures++; $display("FAIL reset_dig_sel got=%b exp=01", dig_sel); end
    checks++; if (dig_al !== 2'b10 || seg_al !== 7'b0000001) begin failures++; $display("FAIL reset_active_low got=%b/%b exp=10/0000001", dig_al, seg_al); end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (dig_sel !== exp_sel[k]) begin failures++; $display("FAIL scan_seq[%0d] got=%b exp=%b", k, dig_sel, exp_sel[k]); end
    end
  endtask

  task automatic test_count_up;
    rst_n = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(3);
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL up_edge3 got=%h exp=00", count); end
    tick();
    checks++; if (count !== 8'h01) begin failures++; $display("FAIL up_edge4 got=%h exp=01", count); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL up_edge4_wrap got=%b exp=0", wrap); end
    tick(4);
    checks++; if (count !== 8'h02) begin failures++; $display("FAIL up_edge8 got=%h exp=02", count); end
    tick(32);
    checks++; if (count !== 8'h10) begin failures++; $display("FAIL up_ten_steps got=%h exp=10", count); end
  endtask

  task automatic test_wrap_up;
    do_load(8'h99);
    checks++; if (count !== 8'h99 || wrap !== 1'b0) begin failures++; $display("FAIL load99 got=%h/%b exp=99/0", count, wrap); end
    en = 1'b1; up = 1'b1;
    tick(3);
    checks++; if (count !== 8'h99) begin failures++; $display("FAIL wrap_up_pre got=%h exp=99", count); end
    tick();
    checks++; if (count !== 8'h00 || wrap !== 1'b1) begin failures++; $display("FAIL wrap_up got=%h/%b exp=00/1", count, wrap); end
    tick();
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_up_pulse got=%b exp=0", wrap); end
  endtask

  task automatic test_wrap_down;
    do_load(8'h00);
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL load00_wrap got=%b exp=0", wrap); end
    en = 1'b1; up = 1'b0;
    tick(4);
    checks++; if (count !== 8'h99 || wrap !== 1'b1) begin failures++; $display("FAIL wrap_down got=%h/%b exp=99/1", count, wrap); end
    tick();
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_down_pulse got=%b exp=0", wrap); end
    tick(3);
    checks++; if (count !== 8'h98) begin failures++; $display("FAIL down_next got=%h exp=98", count); end
  endtask

  task automatic test_priority;
    do_load(8'h42);
    clear = 1'b1; load = 1'b1; load_val = 8'h55;
    tick();
    clear = 1'b0; load = 1'b0;
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL clear_over_load got=%h exp=00", count); end
    do_load(8'hA7);
    checks++; if (count !== 8'h97) begin failures++; $display("FAIL load_saturate got=%h exp=97", count); end
    do_load(8'h3F);
    checks++; if (count !== 8'h39) begin failures++; $display("FAIL load_saturate_lo got=%h exp=39", count); end
    rst_n = 1'b0; load = 1'b1; load_val = 8'h77; en = 1'b1;
    tick();
    rst_n = 1'b1; load = 1'b0; en = 1'b0;
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL reset_over_load got=%h exp=00", count); end
  endtask

  task automatic test_en_pause;
    do_load(8'h00);
    en = 1'b1; up = 1'b1;
    tick(2);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick();
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL pause_early got=%h exp=00", count); end
    tick();
    checks++; if (count !== 8'h01) begin failures++; $display("FAIL pause_step got=%h exp=01", count); end
    do_load(8'h05);
    en = 1'b1; up = 1'b0;
    tick(2);
    up = 1'b1;
    tick(2);
    checks++; if (count !== 8'h06) begin failures++; $display("FAIL dir_on_step got=%h exp=06", count); end
    en = 1'b0;
  endtask

  task automatic test_active_low;
    bit found;
    do_load(8'h12);
    tick();
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (dig_al === 2'b01) found = 1'b1; else tick();
    end
    checks++; if (!found || seg_al !== 7'b1001111) begin failures++; $display("FAIL al_digit1 found=%b got=%b exp=1001111", found, seg_al); end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (dig_al === 2'b10) found = 1'b1; else tick();
    end
    checks++; if (!found || seg_al !== 7'b0010010) begin failures++; $display("FAIL al_digit0 found=%b got=%b exp=0010010", found, seg_al); end
    checks++; if (dig_sel !== 2'b01 || seg !== 7'b1101101) begin failures++; $display("FAIL ah_digit0 got=%b/%b exp=01/1101101", dig_sel, seg); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_priority();
    test_en_pause();
    test_active_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_bcd_counter.md
# seg7_bcd_counter

Parametrised multi-digit BCD up/down counter with a built-in step prescaler and a time-multiplexed seven-segment display driver. It generalises the fixed mod-3 segment counter to DIGITS decimal digits with enable, direction, clear, parallel load and a wrap flag. It sits between the board clock and the seven-segment display pins, and is the standard demo counter for the Verilator flow.

## Interface
Parameters:
- DIGITS, 2: number of BCD digits; legal range 1..8.
- PRESCALE, 4: clock cycles per count step while en=1; legal range ≥1.
- SCAN_DIV, 2: clock cycles each digit is held on the display; legal range ≥1.
- ACTIVE_LOW, 0: when 1, seg and dig_sel are inverted at the output.

Ports:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low, rst_n.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  count enable; gates the prescaler.
- up  in  1  1 = count up, 0 = count down; sampled on each step.
- clear  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous parallel load.
- load_val  in  4*DIGITS  BCD value to load; nibble 0 is the least-significant digit.
- count  out  4*DIGITS  current BCD value, registered.
- wrap  out  1  one-cycle pulse on roll-over (all-9→0 up, 0→all-9 down).
- seg  out  7  segments {A,B,C,D,E,F,G}, with A as the MSB.
- dig_sel  out  DIGITS  one-hot digit enable; bit i selects digit i.

## Operation
- Prescaler pre_cnt: runs 0..PRESCALE-1 and advances only when en=1. It raises an internal step when en=1 and pre_cnt==PRESCALE-1, then returns to 0. It holds while en=0.
- Per-edge priority: rst_n=0 > clear > load > step.
- clear: count=0, pre_cnt=0, wrap=0.
- load: count=load_val, pre_cnt=0, wrap=0.
  - Any load nibble >9 is stored as 9.
  - load_val must never leave count non-BCD.
- Step up: digit 0 increments; 9→0 carries into the next digit. All-9 goes to 0 and pulses wrap.
- Step down: digit 0 decrements; 0→9 borrows from the next digit. All-0 goes to all-9 and pulses wrap.
- Scan: scan_cnt runs 0..SCAN_DIV-1. On its terminal value, digit index idx advances 0→1→…→DIGITS-1→0. Scanning runs regardless of en, clear and load.
- Decode (A..G, active-high) for digits 0–9:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- seg and dig_sel are registered together:
  - dig_sel = 1<<idx.
  - seg = decode(count nibble idx), taken from the current registered count.
  - With ACTIVE_LOW=1, both are bitwise inverted.
- DIGITS=1: dig_sel is constantly 1, and idx is always 0.

## Timing
- Reset values:
  - count = 0 and wrap = 0.
  - pre_cnt, scan_cnt and idx = 0.
  - dig_sel = 1 (digit 0); seg = 1111110 (digit "0").
  - With ACTIVE_LOW=1, dig_sel and seg take the inverted values.
- Step timing: with en held high from reset release, the first step occurs on the PRESCALE-th rising edge with en=1. count and wrap update on that same edge.
- wrap: high for exactly one cycle. It is never asserted on a clear or load edge, even if the count lands on 0 or all-9.
- Display latency: seg/dig_sel reflect idx and count as they stood one edge earlier.
  - A count change appears on seg no earlier than the next edge.
  - It appears only when that digit is scanned.
- Each digit is displayed for SCAN_DIV consecutive cycles; the full frame is DIGITS*SCAN_DIV cycles.
- en falling mid-prescale: pre_cnt freezes and resumes from the same value. No step is lost or duplicated.
- up changing mid-prescale: the direction is taken from up on the step edge only.
- rst_n low for one edge forces all reset values, regardless of clear, load or en.

## Structure
- Package seg7_pkg holds:
  - the BCD_W=4 constant;
  - SEG_W=7 with the A..G bit-ordering convention;
  - the 10-entry segment pattern constants and a decode function returning 1111111 for the unused codes 10–15.
- Sub-module seg7_decode: a purely combinational 4-bit→7-bit decoder that imports seg7_pkg. It is instantiated once, on the scanned nibble.
- Top level contains three things:
  - the prescaler;
  - the BCD counter with a per-digit carry/borrow chain (generate loop over DIGITS);
  - the scan counter plus output registers.

## Test plan
- Reset and scan: DIGITS=2, SCAN_DIV=2, rst_n low 2 cycles then high.
  - Expect count=00, wrap=0, seg=1111110, dig_sel=01.
  - dig_sel then reads 01,01,10,10,01… on successive edges.
- Count up: en=1, up=1, PRESCALE=4 from reset → count=01 at edge 4, 02 at edge 8. Ten steps → count=10 (0x10).
- Wrap up: load 99, then en=1, up=1. On the next step: count=00 and wrap=1 for one cycle only.
- Wrap down: load 00, then up=0. On the next step: count=99 and wrap=1. The next step gives 98.
- Priority and saturation:
  - clear and load asserted together → count=00.
  - load_val=0xA7 → count=97.
  - en toggled low for 3 cycles mid-prescale → the step is delayed by exactly 3 cycles.
- ACTIVE_LOW=1, count=12: while digit 1 is scanned, dig_sel=01 and seg=~0110000 (digit "1"). While digit 0 is scanned, dig_sel=10 and seg=~1101101 (digit "2").
